dc_huff_enc: RTL

- Downstream neighbour of the DC DPCM stage: consumes signed DC differences (one per 8x8 block) and produces JPEG baseline DC entropy codes, i.e. the Huffman size code concatenated with the VLI amplitude bits.
- Two-stage pipeline plus an output FIFO with valid/ready; the upstream DPCM stage has no backpressure, so overflow is detected and flagged.
- Feeds the bitstream packer.

---
 rtl/dc_huff_pkg.sv | 49 ++++
 rtl/dc_huff_fifo.sv | 61 ++++++
 rtl/dc_huff_enc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dc_huff_pkg.sv
// Shared types, mode encodings and JPEG baseline DC Huffman tables
// for the DC entropy encoder.
package dc_huff_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_Y    = 2'b01,
        MODE_CR   = 2'b10,
        MODE_CB   = 2'b11
    } dc_mode_t;

    // Baseline DC categories run 0..11
    localparam int unsigned DC_CATS = 12;

    localparam logic [10:0] LUMA_CODE [DC_CATS] = '{
        11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6,
        11'd14, 11'd30, 11'd62, 11'd126, 11'd254, 11'd510
    };
    localparam logic [3:0] LUMA_LEN [DC_CATS] = '{
        4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

    localparam logic [10:0] CHROMA_CODE [DC_CATS] = '{
        11'd0, 11'd1, 11'd2, 11'd6, 11'd14, 11'd30,
        11'd62, 11'd126, 11'd254, 11'd510, 11'd1022, 11'd2046
    };
    localparam logic [3:0] CHROMA_LEN [DC_CATS] = '{
        4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
    };

    typedef struct packed {
        logic [21:0] bits;
        logic [4:0]  len;
        logic        last;
    } dc_entry_t;

    // Bit length of a magnitude; 0 for a zero magnitude
    function automatic logic [3:0] dc_category(input logic [15:0] mag);
        logic [3:0] cat;
        cat = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mag[i]) cat = 4'(i + 1);
        end
        return cat;
    endfunction

endpackage

// File: rtl/dc_huff_fifo.sv
// First-word fall-through FIFO of DC code entries with sticky overflow.
// A write into a full FIFO succeeds only when a read happens in the same cycle.
module dc_huff_fifo
    import dc_huff_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  dc_entry_t wr_data,
    input  logic      rd_en,
    output dc_entry_t rd_data,
    output logic      full,
    output logic      empty,
    output logic      overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    dc_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Head entry is presented directly; forced to zero while empty
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer, occupancy and sticky overflow tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !do_rd) overflow <= 1'b1;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dc_huff_enc.sv
// JPEG baseline DC entropy encoder: S1 capture/saturate, S2 category,
// amplitude and Huffman lookup, then an output FWFT FIFO.
// Optional statistics outputs (blk_cnt, max_cat) under DC_HUFF_STAT_EN.
module dc_huff_enc
    import dc_huff_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] dpcm_out,
    input  logic          dpcm_done,
    input  logic          dpcm_last,
    output logic [21:0]   out_bits,
    output logic [4:0]    out_len,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow
`ifdef DC_HUFF_STAT_EN
    ,
    output logic [7:0]    blk_cnt,
    output logic [3:0]    max_cat
`endif
);

    localparam logic [DW-1:0] DIFF_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] DIFF_SAT = {1'b1, {(DW-2){1'b0}}, 1'b1};

    logic          accept;
    logic          s1_valid;
    logic [DW-1:0] s1_diff;
    logic          s1_chroma;
    logic          s1_last;

    logic [15:0]   diff_ext;
    logic [15:0]   mag;
    logic [15:0]   amp_src;
    logic [21:0]   amp_mask;
    logic [3:0]    cat;
    logic [3:0]    cat_idx;
    logic [10:0]   code;
    logic [3:0]    code_len;
    dc_entry_t     s2_entry;

    dc_entry_t     rd_entry;
    logic          fifo_full;
    logic          fifo_empty;

    assign accept = dpcm_done && (mode != MODE_IDLE);

    // S1: capture accepted difference, saturating the most negative value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_chroma <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff   <= (dpcm_out == DIFF_MIN) ? DIFF_SAT : dpcm_out;
                s1_chroma <= (mode != MODE_Y);
                s1_last   <= dpcm_last;
            end
        end
    end

    // S2: category, VLI amplitude and table lookup; the FIFO write registers the result
    always_comb begin
        diff_ext = {{(16-DW){s1_diff[DW-1]}}, s1_diff};
        mag      = s1_diff[DW-1] ? (16'd0 - diff_ext) : diff_ext;
        amp_src  = s1_diff[DW-1] ? (diff_ext - 16'd1) : diff_ext;
        cat      = dc_category(mag);
        cat_idx  = (cat > 4'd11) ? 4'd11 : cat;
        amp_mask = (22'd1 << cat) - 22'd1;
        code     = s1_chroma ? CHROMA_CODE[cat_idx] : LUMA_CODE[cat_idx];
        code_len = s1_chroma ? CHROMA_LEN[cat_idx]  : LUMA_LEN[cat_idx];
        s2_entry.bits = ({11'd0, code} << cat) | ({6'd0, amp_src} & amp_mask);
        s2_entry.len  = {1'b0, code_len} + {1'b0, cat};
        s2_entry.last = s1_last;
    end

    dc_huff_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (s1_valid),
        .wr_data  (s2_entry),
        .rd_en    (out_ready),
        .rd_data  (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign out_bits  = rd_entry.bits;
    assign out_len   = rd_entry.len;
    assign out_last  = rd_entry.last;
    assign out_valid = ~fifo_empty;

`ifdef DC_HUFF_STAT_EN
    logic wr_ok;
    logic clr_pend;

    assign wr_ok = s1_valid & (~fifo_full | (out_valid & out_ready));

    // Per-frame statistics; cleared the cycle after a last entry is stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt  <= '0;
            max_cat  <= '0;
            clr_pend <= 1'b0;
        end else begin
            clr_pend <= wr_ok & s2_entry.last;
            if (clr_pend) begin
                blk_cnt <= wr_ok ? 8'd1 : 8'd0;
                max_cat <= wr_ok ? cat : 4'd0;
            end else if (wr_ok) begin
                blk_cnt <= blk_cnt + 8'd1;
                if (cat > max_cat) max_cat <= cat;
            end
        end
    end
`endif

endmodule
